// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ producers.
// The winning write is registered and presented on rf_* one cycle after acceptance.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16,
    localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        hold,
    input  logic                        cnt_clear,
    output logic                        rf_reg_write,
    output logic [ADDR_W-1:0]           rf_write_addr,
    output logic [DATA_W-1:0]           rf_write_data,
    output logic [GID_W-1:0]            grant_id,
    output logic [CNT_W-1:0]            contention_cnt
);

    // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
    // req_ready is combinational, one-hot, and may depend on req_valid of the same cycle.

    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [GID_W-1:0]  win_idx;
    logic              win_found;
    logic              xfer;
    logic              contended;
    logic              rf_reg_write_q, rf_reg_write_d;
    logic [ADDR_W-1:0] rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
    logic [GID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hold && !win_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = GID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign xfer = win_found && rst_n;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more requesters are valid.
    assign contended = |(req_valid & (req_valid - 1'b1)) && !hold;

    always_comb begin
        ptr_d           = ptr_q;
        rf_reg_write_d  = xfer;
        rf_write_addr_d = rf_write_addr_q;
        rf_write_data_d = rf_write_data_q;
        grant_id_d      = grant_id_q;
        cnt_d           = cnt_q;
        if (xfer) begin
            ptr_d           = (win_idx == GID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            rf_write_addr_d = req_addr[win_idx*ADDR_W +: ADDR_W];
            rf_write_data_d = req_data[win_idx*DATA_W +: DATA_W];
            grant_id_d      = win_idx;
        end
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (contended && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q           <= '0;
            rf_reg_write_q  <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
            grant_id_q      <= '0;
            cnt_q           <= '0;
        end else begin
            ptr_q           <= ptr_d;
            rf_reg_write_q  <= rf_reg_write_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
            grant_id_q      <= grant_id_d;
            cnt_q           <= cnt_d;
        end
    end

    assign rf_reg_write   = rf_reg_write_q;
    assign rf_write_addr  = rf_write_addr_q;
    assign rf_write_data  = rf_write_data_q;
    assign grant_id       = grant_id_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected RF writes into a queue,
// a negedge monitor pops and compares each presented strobe.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;
  localparam int EXP_W   = 2 + ADDR_W + DATA_W;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      hold;
  logic                      cnt_clear;
  logic                      rf_reg_write;
  logic [ADDR_W-1:0]         rf_write_addr;
  logic [DATA_W-1:0]         rf_write_data;
  logic [1:0]                grant_id;
  logic [CNT_W-1:0]          contention_cnt;

  logic [ADDR_W-1:0] a_tab [NUM_REQ];
  logic [DATA_W-1:0] d_tab [NUM_REQ];
  logic [EXP_W-1:0]  exp_q [$];

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .hold(hold), .cnt_clear(cnt_clear),
    .rf_reg_write(rf_reg_write), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .grant_id(grant_id),
    .contention_cnt(contention_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    a_tab[0] = 5'd3;  d_tab[0] = 32'h1111_0000;
    a_tab[1] = 5'd12; d_tab[1] = 32'h2222_0001;
    a_tab[2] = 5'd7;  d_tab[2] = 32'hDEAD_BEEF;
    a_tab[3] = 5'd31; d_tab[3] = 32'h4444_0003;
  end

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = a_tab[i];
      req_data[i*DATA_W +: DATA_W] = d_tab[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs already applied at posedge+1; check ready at negedge, log expected write
  task automatic step(input logic [NUM_REQ-1:0] exp_rdy, input bit push = 1'b1);
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (push) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_rdy[i]) exp_q.push_back({2'(i), a_tab[i], d_tab[i]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rf_reg_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 64'(rf_reg_write), 64'd0);
      end else begin
        chk("rf_write", 64'({grant_id, rf_write_addr, rf_write_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; hold = 1'b0; cnt_clear = 1'b0;

    // reset with all requesters valid
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_strobe", 64'(rf_reg_write), 64'd0);
    chk("rst_cnt", 64'(contention_cnt), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_addr", 64'(rf_write_addr), 64'd0);
    chk("rst_data", 64'(rf_write_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // round robin over 8 contended cycles starting at requester 0
    for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)));
    chk("rr_cnt", 64'(contention_cnt), 64'd8);
    req_valid = 4'h0; step(4'b0000);

    // hold after grant to 1
    req_valid = 4'hF;
    step(4'b0001);
    step(4'b0010);
    hold = 1'b1;
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);
    chk("hold_strobe_low", 64'(rf_reg_write), 64'd0);
    chk("hold_cnt", 64'(contention_cnt), 64'd10);
    hold = 1'b0;
    step(4'b0100);
    req_valid = 4'h0; step(4'b0000);

    // single requester 2, addr 7, data DEADBEEF
    req_valid = 4'b0100; step(4'b0100);
    req_valid = 4'h0;    step(4'b0000);
    chk("single_cnt", 64'(contention_cnt), 64'd11);

    // mixed patterns, pointer at 3
    req_valid = 4'b1010; step(4'b1000); step(4'b0010);
    req_valid = 4'b0011; step(4'b0001); step(4'b0010);
    req_valid = 4'h0;    step(4'b0000);

    // clear, then saturate, then clear while contended
    cnt_clear = 1'b1; step(4'b0000);
    cnt_clear = 1'b0;
    chk("clear_cnt", 64'(contention_cnt), 64'd0);
    req_valid = 4'hF;
    for (int k = 0; k < 20; k++) step(4'(1 << ((2 + k) % 4)));
    chk("sat_cnt", 64'(contention_cnt), 64'd15);
    cnt_clear = 1'b1; step(4'b0100);
    cnt_clear = 1'b0;
    chk("clear_wins_cnt", 64'(contention_cnt), 64'd0);
    req_valid = 4'h0; step(4'b0000);

    // async reset between accept and strobe
    req_valid = 4'b0100;
    @(negedge clk);
    chk("pre_reset_ready", 64'(req_ready), 64'b0100);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_drop_strobe", 64'(rf_reg_write), 64'd0);
    @(negedge clk);
    chk("reset_ready_low", 64'(req_ready), 64'd0);
    chk("reset_drop_strobe2", 64'(rf_reg_write), 64'd0);
    req_valid = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(4'b0001);
    req_valid = 4'h0;
    step(4'b0000);
    step(4'b0000);

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
